// File: rtl/mod_addsub_precompute.sv
// ---------------------------------------------------------------------------
// mod_addsub_precompute
//
// Second stage of the modular adder/subtractor. Each operation passes through
// two register stages. S1 holds the raw sum/difference with its carry/borrow.
// S2 holds both candidate results and the flag that tells the downstream
// chooser which candidate is the reduced result.
//
// Ports
//   clk              rising-edge clock
//   rst_n            synchronous active-low reset
//   in_valid         upstream offers an operation
//   in_ready         an offered operation is taken this cycle
//   op               0 = x+y mod m, 1 = x-y mod m
//   x, y             operands (nominally < m)
//   m                modulus (nominally >= 1)
//   out_valid        v/w/condition_result hold a valid result
//   out_ready        downstream takes the result this cycle
//   v                uncorrected result
//   w                modulus-corrected result
//   condition_result 1 = final result is w, 0 = final result is v
// ---------------------------------------------------------------------------
module mod_addsub_precompute #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] w,
  output logic             condition_result
);

  logic             s1Valid_q, s1Valid_d;
  logic             s1Op_q, s1Op_d;
  logic [WIDTH-1:0] s1M_q, s1M_d;
  logic [WIDTH:0]   s1Raw_q, s1Raw_d;

  logic             s2Valid_q, s2Valid_d;
  logic [WIDTH-1:0] s2V_q, s2V_d;
  logic [WIDTH-1:0] s2W_q, s2W_d;
  logic             s2Cond_q, s2Cond_d;

  logic             s2Adv;
  logic             s1Adv;
  logic [WIDTH:0]   rawValue;

  // A stage may load whenever it is empty or the stage after it is moving.
  // in_ready therefore follows out_ready combinationally through both stages.
  assign s2Adv    = !s2Valid_q || out_ready;
  assign s1Adv    = !s1Valid_q || s2Adv;
  assign in_ready = s1Adv;

  // The raw value is one bit wider than the operands. For add the extra bit
  // is the carry; for subtract it is the two's-complement borrow.
  always_comb begin
    if (op) begin
      rawValue = {1'b0, x} - {1'b0, y};
    end else begin
      rawValue = {1'b0, x} + {1'b0, y};
    end
  end

  // S1 next state: take new data only when an operation is offered. When the
  // stage advances with nothing offered, only the valid bit clears.
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Op_d    = s1Op_q;
    s1M_d     = s1M_q;
    s1Raw_d   = s1Raw_q;
    if (s1Adv) begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        s1Op_d  = op;
        s1M_d   = m;
        s1Raw_d = rawValue;
      end
    end
  end

  // S2 next state: form both candidates from S1. For add, the comparison is
  // done at full raw width so a carry-out always selects the corrected value.
  // For subtract, a borrow means the difference went negative and needs +m.
  always_comb begin
    s2Valid_d = s2Valid_q;
    s2V_d     = s2V_q;
    s2W_d     = s2W_q;
    s2Cond_d  = s2Cond_q;
    if (s2Adv) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2V_d = s1Raw_q[WIDTH-1:0];
        if (s1Op_q) begin
          s2W_d    = s1Raw_q[WIDTH-1:0] + s1M_q;
          s2Cond_d = s1Raw_q[WIDTH];
        end else begin
          s2W_d    = s1Raw_q[WIDTH-1:0] - s1M_q;
          s2Cond_d = (s1Raw_q >= {1'b0, s1M_q});
        end
      end
    end
  end

  // Pipeline registers. Reset discards anything in flight and zeroes the data
  // so the outputs read as zero until new work arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Op_q    <= 1'b0;
      s1M_q     <= '0;
      s1Raw_q   <= '0;
      s2Valid_q <= 1'b0;
      s2V_q     <= '0;
      s2W_q     <= '0;
      s2Cond_q  <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Op_q    <= s1Op_d;
      s1M_q     <= s1M_d;
      s1Raw_q   <= s1Raw_d;
      s2Valid_q <= s2Valid_d;
      s2V_q     <= s2V_d;
      s2W_q     <= s2W_d;
      s2Cond_q  <= s2Cond_d;
    end
  end

  assign out_valid        = s2Valid_q;
  assign v                = s2V_q;
  assign w                = s2W_q;
  assign condition_result = s2Cond_q;

endmodule

// File: tb/tb_mod_addsub_precompute.sv
// ---------------------------------------------------------------------------
// tb_mod_addsub_precompute
//
// Directed and streaming checks for mod_addsub_precompute at WIDTH = 4.
// Expected results come from hand-computed tables for the directed vectors
// and from a small integer model for the random stream.
// ---------------------------------------------------------------------------
module tb_mod_addsub_precompute;

  typedef struct packed {
    logic [3:0] v;
    logic [3:0] w;
    logic       c;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       op;
  logic [3:0] x;
  logic [3:0] y;
  logic [3:0] m;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] v;
  logic [3:0] w;
  logic       condition_result;

  int checkCount;
  int failCount;
  int drained;

  exp_t expQ[$];
  exp_t nextExp;

  logic       dirOp[4];
  logic [3:0] dirX[4];
  logic [3:0] dirY[4];
  logic [3:0] dirM[4];
  exp_t       dirExp[4];

  mod_addsub_precompute #(.WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .x(x),
    .y(y),
    .m(m),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .v(v),
    .w(w),
    .condition_result(condition_result)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case any sequence hangs.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Integer reference for one operation.
  function automatic exp_t modelOp(input logic o, input logic [3:0] a, input logic [3:0] b,
                                   input logic [3:0] mm);
    exp_t r;
    int ia, ib, im, s;
    ia = a; ib = b; im = mm;
    if (!o) begin
      s   = ia + ib;
      r.v = 4'((s) % 16);
      r.w = 4'((s - im + 32) % 16);
      r.c = (s >= im);
    end else begin
      s   = ia - ib;
      r.v = 4'((s + 16) % 16);
      r.w = 4'((s + 16 + im) % 16);
      r.c = (ia < ib);
    end
    return r;
  endfunction

  // Drive one vector onto the input pins along with its expected result.
  task automatic applyStimulus(input logic o, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] mm, input exp_t e);
    in_valid = 1'b1;
    op       = o;
    x        = a;
    y        = b;
    m        = mm;
    nextExp  = e;
  endtask

  // One clock cycle with scoreboard bookkeeping done on the settled values
  // just before the edge: drains are compared, accepts are queued.
  task automatic runCycle();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_v", 32'(v), 32'(e.v));
        checkOutput("sb_w", 32'(w), 32'(e.w));
        checkOutput("sb_cond", 32'(condition_result), 32'(e.c));
      end
      drained++;
    end
    if (in_valid && in_ready) expQ.push_back(nextExp);
    @(posedge clk);
    #1;
  endtask

  task automatic drainAll(input int budget, input int expectDrained);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (expQ.size() != 0 && n < budget) begin
      runCycle();
      n++;
    end
    checkOutput("drain_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("drain_count", 32'(drained), 32'(expectDrained));
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    drained    = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    op         = 1'b0;
    x          = '0;
    y          = '0;
    m          = '0;
    out_ready  = 1'b1;
    nextExp    = '0;

    // Hand-computed vectors, m = 13.
    dirOp[0] = 1'b0; dirX[0] = 4'd9; dirY[0] = 4'd7; dirM[0] = 4'd13; dirExp[0] = '{v: 4'd0,  w: 4'd3,  c: 1'b1};
    dirOp[1] = 1'b0; dirX[1] = 4'd3; dirY[1] = 4'd4; dirM[1] = 4'd13; dirExp[1] = '{v: 4'd7,  w: 4'd10, c: 1'b0};
    dirOp[2] = 1'b1; dirX[2] = 4'd3; dirY[2] = 4'd5; dirM[2] = 4'd13; dirExp[2] = '{v: 4'd14, w: 4'd11, c: 1'b1};
    dirOp[3] = 1'b1; dirX[3] = 4'd9; dirY[3] = 4'd4; dirM[3] = 4'd13; dirExp[3] = '{v: 4'd5,  w: 4'd2,  c: 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_v", 32'(v), 32'd0);
    checkOutput("rst_w", 32'(w), 32'd0);
    checkOutput("rst_cond", 32'(condition_result), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Each directed vector alone: latency and hand-computed values.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(dirOp[i], dirX[i], dirY[i], dirM[i], dirExp[i]);
      runCycle();
      in_valid = 1'b0;
      #1;
      checkOutput("lat_not_yet", 32'(out_valid), 32'd0);
      runCycle();
      checkOutput("lat_valid", 32'(out_valid), 32'd1);
      checkOutput("dir_v", 32'(v), 32'(dirExp[i].v));
      checkOutput("dir_w", 32'(w), 32'(dirExp[i].w));
      checkOutput("dir_cond", 32'(condition_result), 32'(dirExp[i].c));
      runCycle();
      checkOutput("dir_drained", 32'(out_valid), 32'd0);
    end
    checkOutput("dir_count", 32'(drained), 32'd4);

    // Backpressure: two accepts fill the pipe, then a five-cycle stall.
    drained   = 0;
    out_ready = 1'b0;
    applyStimulus(dirOp[0], dirX[0], dirY[0], dirM[0], dirExp[0]);
    runCycle();
    applyStimulus(dirOp[1], dirX[1], dirY[1], dirM[1], dirExp[1]);
    runCycle();
    applyStimulus(dirOp[2], dirX[2], dirY[2], dirM[2], dirExp[2]);
    #1;
    checkOutput("bp_full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_stall_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_stall_v", 32'(v), 32'(dirExp[0].v));
      checkOutput("bp_stall_w", 32'(w), 32'(dirExp[0].w));
      checkOutput("bp_stall_cond", 32'(condition_result), 32'(dirExp[0].c));
      checkOutput("bp_stall_in_ready", 32'(in_ready), 32'd0);
      runCycle();
    end
    checkOutput("bp_accepted_two", 32'(expQ.size()), 32'd2);
    out_ready = 1'b1;
    #1;
    checkOutput("bp_in_ready_rises", 32'(in_ready), 32'd1);
    runCycle();
    applyStimulus(dirOp[3], dirX[3], dirY[3], dirM[3], dirExp[3]);
    runCycle();
    drainAll(10, 4);

    // Full throughput: random back-to-back operations.
    drained = 0;
    for (int i = 0; i < 16; i++) begin
      logic       ro;
      logic [3:0] ra, rb, rm;
      ro = 1'($urandom_range(0, 1));
      rm = 4'($urandom_range(1, 15));
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      applyStimulus(ro, ra, rb, rm, modelOp(ro, ra, rb, rm));
      #1;
      checkOutput("tput_in_ready", 32'(in_ready), 32'd1);
      if (i >= 2) checkOutput("tput_out_valid", 32'(out_valid), 32'd1);
      runCycle();
    end
    drainAll(10, 16);

    // Reset with two operations in flight.
    out_ready = 1'b0;
    applyStimulus(dirOp[0], dirX[0], dirY[0], dirM[0], dirExp[0]);
    runCycle();
    applyStimulus(dirOp[2], dirX[2], dirY[2], dirM[2], dirExp[2]);
    runCycle();
    checkOutput("mid_out_valid_pre", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expQ.delete();
    out_ready = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_v", 32'(v), 32'd0);
    checkOutput("mid_rst_w", 32'(w), 32'd0);
    checkOutput("mid_rst_cond", 32'(condition_result), 32'd0);
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      runCycle();
      checkOutput("mid_no_stale", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/mod_addsub_precompute.md
# mod_addsub_precompute

Second pipeline stage of the modular adder/subtractor. Accepts operands `x`, `y`, modulus `m` and an add/sub select, and produces the uncorrected result `v`, the modulus-corrected candidate `w` and the `condition_result` flag consumed directly by the third-stage result chooser. The block is a two-register pipeline with valid/ready handshaking on both sides. It sustains one operation per cycle and propagates backpressure without losing or duplicating data.

## Interface
- `WIDTH`, 4, operand/modulus/result width in bits (≥2)
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `in_valid`  in  1  upstream holds a valid operation
- `in_ready`  out  1  block accepts the operation this cycle
- `op`  in  1  0 = add (x+y mod m), 1 = subtract (x−y mod m)
- `x`, `y`  in  WIDTH  operands, nominally < m
- `m`  in  WIDTH  modulus, nominally ≥1
- `out_valid`  out  1  `v`/`w`/`condition_result` valid
- `out_ready`  in  1  downstream accepts this cycle
- `v`  out  WIDTH  uncorrected result (maps to chooser v3..v0)
- `w`  out  WIDTH  corrected result (maps to chooser w3..w0)
- `condition_result`  out  1  1 = final result is `w`, 0 = final result is `v`

## Operation
- Transfer on the input side happens when `in_valid && in_ready`. Transfer on the output side happens when `out_valid && out_ready`.
- Stage 1 (S1) register captures `op` and `m`, plus the raw value `r` (WIDTH+1 bits):
  - add: `r = x + y` (carry kept in the MSB)
  - sub: `r = x − y` in two's complement WIDTH+1 bits; `r[WIDTH]` is the borrow
- Stage 2 (S2) register captures outputs computed from S1:
  - `v = r[WIDTH-1:0]`
  - add: `w = (r − m) mod 2^WIDTH`; `condition_result = (r ≥ m)`, compared at WIDTH+1 bits, so carry-out cases always select `w`
  - sub: `w = (r[WIDTH-1:0] + m) mod 2^WIDTH`; `condition_result = r[WIDTH]` (borrow)
- Out-of-range inputs (x or y ≥ m, or m = 0) are not errors. The formulas above apply unchanged; the result is simply not guaranteed to be reduced.
- Stage advance rules:
  - `s2_adv = !s2_valid || out_ready`
  - `s1_adv = !s1_valid || s2_adv`
  - `in_ready = s1_adv`, which is combinational from `out_ready`
- When a stage advances with no incoming valid data, its valid bit clears; its data registers may hold stale values.
- When S2 is stalled (`out_valid && !out_ready`), `v`, `w`, `condition_result` and `out_valid` hold stable.
- Order is strictly preserved. Capacity is 2 operations in flight.

## Timing
- Reset (`rst_n` = 0 at a rising edge): S1/S2 valid bits clear, and all data registers clear to 0. After reset, `out_valid` = 0, `v` = 0, `w` = 0, `condition_result` = 0.
- `in_ready` evaluates to 1 in the first cycle after reset.
- Latency: an operation accepted at edge k is presented with `out_valid` = 1 after edge k+2, provided no stall occurs.
- Throughput: 1 op/cycle while `out_ready` = 1.
- Full: when both stages are valid and `out_ready` = 0, `in_ready` = 0. When `out_ready` rises, `in_ready` rises in the same cycle, and a new op may be accepted on the same edge that S2 drains.
- Simultaneous accept and drain in the same cycle is legal; no bubble is inserted.
- Reset mid-operation: all in-flight ops are discarded. No `out_valid` pulse occurs until new input is accepted after reset deasserts.
- Input signals are ignored when `in_ready` = 0.

## Test plan
- Add with wrap, WIDTH=4, m=13, x=9, y=7: expect `v`=0, `w`=3, `condition_result`=1, two edges after accept.
- Add without correction, m=13, x=3, y=4: expect `v`=7, `w`=10, `condition_result`=0.
- Sub with borrow, m=13, x=3, y=5: expect `v`=14, `w`=11, `condition_result`=1. Sub without borrow, x=9, y=4: expect `v`=5, `w`=2, `condition_result`=0.
- Backpressure: stream 4 ops (the four above) with `out_ready`=0 for 5 cycles.
  - `in_ready` drops after 2 accepts.
  - Outputs stay stable while stalled.
  - After release, all 4 results emerge in order with no loss or duplication.
- Full throughput: 16 random back-to-back ops with `out_ready`=1. Expect one result per cycle, each matching a reference model.
- Reset mid-stream: assert `rst_n`=0 for 1 edge with 2 ops in flight. Expect `out_valid`=0 and all outputs = 0 afterwards, and no stale result emitted.
